// File: rtl/scoreboard_regfile.sv
// Register file with busy-bit scoreboard: issue requests are held back on RAW/WAW
// hazards, source operands are forwarded from same-cycle write-backs.
module scoreboard_regfile #(
  parameter  int XLEN     = 32,
  parameter  int RF_DEPTH = 32,
  parameter  int NUM_WR   = 2,
  localparam int AW       = $clog2(RF_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_tvalid,
  output logic                     id_tready,
  input  logic [AW-1:0]            id_rs1,
  input  logic [AW-1:0]            id_rs2,
  input  logic                     id_rs1_en,
  input  logic                     id_rs2_en,
  input  logic [AW-1:0]            id_rd,
  input  logic                     id_rd_en,
  output logic                     ex_tvalid,
  input  logic                     ex_tready,
  output logic [XLEN-1:0]          ex_rs1_data,
  output logic [XLEN-1:0]          ex_rs2_data,
  output logic [AW-1:0]            ex_rd,
  output logic                     ex_rd_en,
  input  logic [NUM_WR-1:0]        wb_tvalid,
  input  logic [NUM_WR*AW-1:0]     wb_rd,
  input  logic [NUM_WR*XLEN-1:0]   wb_wdata,
  output logic [NUM_WR-1:0]        wb_tready,
  input  logic                     invalidate
);

  logic [XLEN-1:0]     rf_q [RF_DEPTH];
  logic [RF_DEPTH-1:0] busy_q;
  logic [RF_DEPTH-1:0] wb_clr;
  logic [RF_DEPTH-1:0] busy_set;
  logic [NUM_WR-1:0]   wb_eff;

  logic [XLEN-1:0]     rs1_data_p0;
  logic [XLEN-1:0]     rs2_data_p0;
  logic                rs1_haz_p0;
  logic                rs2_haz_p0;
  logic                rd_haz_p0;
  logic                issue_acc_p0;

  logic                vld_p1;
  logic [XLEN-1:0]     rs1_data_p1;
  logic [XLEN-1:0]     rs2_data_p1;
  logic [AW-1:0]       rd_p1;
  logic                rd_en_p1;

  assign wb_tready = '1;

  // Stage p0: decode write-backs, forward operands, detect hazards
  always_comb begin
    wb_clr = '0;
    wb_eff = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      wb_eff[k] = wb_tvalid[k] && (wb_rd[k*AW +: AW] != '0);
      if (wb_eff[k]) wb_clr[wb_rd[k*AW +: AW]] = 1'b1;
    end
  end

  // Ascending port scan so the highest-index matching write overrides lower ones
  always_comb begin
    rs1_data_p0 = rf_q[id_rs1];
    rs2_data_p0 = rf_q[id_rs2];
    for (int k = 0; k < NUM_WR; k++) begin
      if (wb_eff[k] && (wb_rd[k*AW +: AW] == id_rs1)) rs1_data_p0 = wb_wdata[k*XLEN +: XLEN];
      if (wb_eff[k] && (wb_rd[k*AW +: AW] == id_rs2)) rs2_data_p0 = wb_wdata[k*XLEN +: XLEN];
    end
    if (!id_rs1_en || (id_rs1 == '0)) rs1_data_p0 = '0;
    if (!id_rs2_en || (id_rs2 == '0)) rs2_data_p0 = '0;
  end

  // busy_q[0] is never set, so x0 sources can never raise a hazard
  assign rs1_haz_p0   = id_rs1_en && busy_q[id_rs1] && !wb_clr[id_rs1];
  assign rs2_haz_p0   = id_rs2_en && busy_q[id_rs2] && !wb_clr[id_rs2];
  assign rd_haz_p0    = id_rd_en && (id_rd != '0) && busy_q[id_rd] && !wb_clr[id_rd];
  assign id_tready    = !rst && !rs1_haz_p0 && !rs2_haz_p0 && !rd_haz_p0 && !invalidate &&
                        (!vld_p1 || ex_tready);
  assign issue_acc_p0 = id_tvalid && id_tready;

  always_comb begin
    busy_set = '0;
    if (issue_acc_p0 && id_rd_en && (id_rd != '0)) busy_set[id_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else if (invalidate) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~wb_clr) | busy_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wb_eff[k]) rf_q[wb_rd[k*AW +: AW]] <= wb_wdata[k*XLEN +: XLEN];
      end
    end
  end

  // Stage p1: registered issue output toward execution units
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      rd_p1       <= '0;
      rd_en_p1    <= 1'b0;
    end else if (invalidate) begin
      vld_p1      <= 1'b0;
    end else if (issue_acc_p0) begin
      vld_p1      <= 1'b1;
      rs1_data_p1 <= rs1_data_p0;
      rs2_data_p1 <= rs2_data_p0;
      rd_p1       <= id_rd;
      rd_en_p1    <= id_rd_en;
    end else if (ex_tready) begin
      vld_p1      <= 1'b0;
    end
  end

  assign ex_tvalid   = vld_p1;
  assign ex_rs1_data = rs1_data_p1;
  assign ex_rs2_data = rs2_data_p1;
  assign ex_rd       = rd_p1;
  assign ex_rd_en    = rd_en_p1;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Randomized bench for scoreboard_regfile against an array/busy-flag reference model,
// preceded by directed hazard, forwarding, stall, flush and reset scenarios.
module tb_scoreboard_regfile;
  localparam int XLEN = 32;
  localparam int RF   = 32;
  localparam int NW   = 2;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_tvalid, id_tready;
  logic [AW-1:0]     id_rs1, id_rs2, id_rd;
  logic              id_rs1_en, id_rs2_en, id_rd_en;
  logic              ex_tvalid, ex_tready;
  logic [XLEN-1:0]   ex_rs1_data, ex_rs2_data;
  logic [AW-1:0]     ex_rd;
  logic              ex_rd_en;
  logic [NW-1:0]     wb_tvalid, wb_tready;
  logic [NW*AW-1:0]  wb_rd;
  logic [NW*XLEN-1:0] wb_wdata;
  logic              invalidate;

  scoreboard_regfile #(.XLEN(XLEN), .RF_DEPTH(RF), .NUM_WR(NW)) dut (
    .clk(clk), .rst(rst),
    .id_tvalid(id_tvalid), .id_tready(id_tready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_rd(id_rd), .id_rd_en(id_rd_en),
    .ex_tvalid(ex_tvalid), .ex_tready(ex_tready),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_rd_en(ex_rd_en),
    .wb_tvalid(wb_tvalid), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .wb_tready(wb_tready),
    .invalidate(invalidate)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // staged stimulus, applied just after a falling edge
  logic              s_id_tvalid, s_rs1_en, s_rs2_en, s_rd_en, s_ex_tready, s_inval;
  logic [AW-1:0]     s_rs1, s_rs2, s_rd;
  logic [NW-1:0]     s_wb_tvalid;
  logic [NW*AW-1:0]  s_wb_rd;
  logic [NW*XLEN-1:0] s_wb_wdata;

  // reference model state
  logic [XLEN-1:0]   m_rf [RF];
  bit                m_busy [RF];
  bit                m_vld;
  logic [XLEN-1:0]   m_rs1, m_rs2;
  logic [AW-1:0]     m_rd;
  bit                m_rd_en;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_written(input logic [AW-1:0] idx);
    if (idx == 0) return 1'b0;
    for (int k = 0; k < NW; k++)
      if (wb_tvalid[k] && wb_rd[k*AW +: AW] == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] idx, input logic en);
    logic [XLEN-1:0] v;
    if (!en || idx == 0) return '0;
    v = m_rf[idx];
    for (int k = 0; k < NW; k++)
      if (wb_tvalid[k] && wb_rd[k*AW +: AW] == idx) v = wb_wdata[k*XLEN +: XLEN];
    return v;
  endfunction

  function automatic bit m_ready();
    if (rst || invalidate) return 1'b0;
    if (m_vld && !ex_tready) return 1'b0;
    if (id_rs1_en && m_busy[id_rs1] && !m_written(id_rs1)) return 1'b0;
    if (id_rs2_en && m_busy[id_rs2] && !m_written(id_rs2)) return 1'b0;
    if (id_rd_en && id_rd != 0 && m_busy[id_rd] && !m_written(id_rd)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < RF; i++) begin
      m_rf[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_vld = 1'b0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_rd_en = 1'b0;
  endtask

  task automatic idle_stage();
    s_id_tvalid = 1'b0; s_rs1_en = 1'b0; s_rs2_en = 1'b0; s_rd_en = 1'b0;
    s_rs1 = '0; s_rs2 = '0; s_rd = '0;
    s_ex_tready = 1'b1; s_inval = 1'b0;
    s_wb_tvalid = '0; s_wb_rd = '0; s_wb_wdata = '0;
  endtask

  task automatic apply();
    id_tvalid = s_id_tvalid; id_rs1 = s_rs1; id_rs2 = s_rs2; id_rd = s_rd;
    id_rs1_en = s_rs1_en; id_rs2_en = s_rs2_en; id_rd_en = s_rd_en;
    ex_tready = s_ex_tready; invalidate = s_inval;
    wb_tvalid = s_wb_tvalid; wb_rd = s_wb_rd; wb_wdata = s_wb_wdata;
  endtask

  // one clock: check registered outputs, apply staged inputs, check ready, advance model
  task automatic step();
    bit rdy, acc;
    logic [XLEN-1:0] r1, r2;
    @(negedge clk);
    chk("ex_out", {ex_tvalid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_en},
                  {m_vld, m_rs1, m_rs2, m_rd, m_rd_en});
    apply();
    #1;
    rdy = m_ready();
    chk("id_tready", id_tready, rdy);
    acc = id_tvalid && rdy;
    r1 = m_read(id_rs1, id_rs1_en);
    r2 = m_read(id_rs2, id_rs2_en);
    if (invalidate) begin
      for (int i = 0; i < RF; i++) m_busy[i] = 1'b0;
    end else begin
      for (int i = 1; i < RF; i++) if (m_written(AW'(i))) m_busy[i] = 1'b0;
      if (acc && id_rd_en && id_rd != 0) m_busy[id_rd] = 1'b1;
    end
    for (int k = 0; k < NW; k++)
      if (wb_tvalid[k] && wb_rd[k*AW +: AW] != 0) m_rf[wb_rd[k*AW +: AW]] = wb_wdata[k*XLEN +: XLEN];
    if (invalidate) m_vld = 1'b0;
    else if (acc) begin
      m_vld = 1'b1; m_rs1 = r1; m_rs2 = r2; m_rd = id_rd; m_rd_en = id_rd_en;
    end else if (ex_tready) m_vld = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic rs1_en, input logic [AW-1:0] rd,
                       input logic rd_en);
    s_id_tvalid = 1'b1; s_rs1 = rs1; s_rs1_en = rs1_en; s_rd = rd; s_rd_en = rd_en;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_stage();
    apply();
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ex", {ex_tvalid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_en}, '0);
    chk("reset_tready", id_tready, 1'b0);
    rst = 1'b0;

    // write then read back through the array
    idle_stage(); s_wb_tvalid = 2'b01; s_wb_rd = {5'd0, 5'd5}; s_wb_wdata = {32'h0, 32'h1234}; step();
    idle_stage(); issue(5'd5, 1'b1, 5'd0, 1'b0); step();
    chk("wr_rd_ready", id_tready, 1'b1);
    idle_stage(); step();
    chk("wr_rd_data", ex_rs1_data, 32'h1234);

    // RAW stall until port 1 writes the destination
    idle_stage(); issue(5'd0, 1'b0, 5'd7, 1'b1); step();
    for (int i = 0; i < 3; i++) begin
      idle_stage(); issue(5'd7, 1'b1, 5'd0, 1'b0); step();
      chk("raw_stall", id_tready, 1'b0);
    end
    idle_stage(); issue(5'd7, 1'b1, 5'd0, 1'b0);
    s_wb_tvalid = 2'b10; s_wb_rd = {5'd7, 5'd0}; s_wb_wdata = {32'hAA, 32'h0}; step();
    chk("raw_release", id_tready, 1'b1);
    idle_stage(); step();
    chk("raw_fwd_data", ex_rs1_data, 32'hAA);

    // same-index write priority and x0 hardwiring
    idle_stage(); s_wb_tvalid = 2'b11; s_wb_rd = {5'd3, 5'd3}; s_wb_wdata = {32'h22, 32'h11}; step();
    idle_stage(); issue(5'd3, 1'b1, 5'd0, 1'b0); s_rs2 = 5'd0; s_rs2_en = 1'b1;
    s_wb_tvalid = 2'b01; s_wb_rd = {5'd0, 5'd0}; s_wb_wdata = {32'h0, 32'hFF}; step();
    idle_stage(); step();
    chk("prio_x3", ex_rs1_data, 32'h22);
    chk("x0_zero", ex_rs2_data, 32'h0);

    // output back-pressure then full-rate issue
    idle_stage(); issue(5'd3, 1'b1, 5'd0, 1'b0); s_ex_tready = 1'b0; step();
    for (int i = 0; i < 3; i++) begin
      idle_stage(); issue(5'd5, 1'b1, 5'd0, 1'b0); s_ex_tready = 1'b0; step();
      chk("bp_stall", id_tready, 1'b0);
      chk("bp_hold", {ex_tvalid, ex_rs1_data}, {1'b1, 32'h22});
    end
    for (int i = 0; i < 4; i++) begin
      idle_stage(); issue(AW'(i + 1), 1'b1, 5'd0, 1'b0); step();
      chk("b2b_ready", id_tready, 1'b1);
    end

    // flush clears pending output and busy bits
    idle_stage(); issue(5'd0, 1'b0, 5'd9, 1'b1); step();
    idle_stage(); issue(5'd1, 1'b1, 5'd0, 1'b0); s_inval = 1'b1; step();
    chk("flush_block", id_tready, 1'b0);
    idle_stage(); issue(5'd9, 1'b1, 5'd0, 1'b0); step();
    chk("flush_vld", ex_tvalid, 1'b0);
    chk("flush_busy_clr", id_tready, 1'b1);

    // asynchronous reset mid-cycle
    idle_stage(); issue(5'd0, 1'b0, 5'd9, 1'b1); s_ex_tready = 1'b0; step();
    idle_stage(); s_ex_tready = 1'b0; step();
    chk("pre_rst_vld", ex_tvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ex", {ex_tvalid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_en}, '0);
    chk("async_rst_tready", id_tready, 1'b0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_stage(); issue(5'd9, 1'b1, 5'd9, 1'b1); step();
    chk("rst_busy_clr", id_tready, 1'b1);

    // randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      s_id_tvalid = ($urandom_range(0, 3) != 0);
      s_rs1 = AW'($urandom_range(0, 7)); s_rs2 = AW'($urandom_range(0, 7));
      s_rd  = AW'($urandom_range(0, 7));
      s_rs1_en = ($urandom_range(0, 1) == 1); s_rs2_en = ($urandom_range(0, 1) == 1);
      s_rd_en  = ($urandom_range(0, 1) == 1);
      s_ex_tready = ($urandom_range(0, 3) != 0);
      s_inval = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < NW; k++) begin
        s_wb_tvalid[k] = ($urandom_range(0, 9) < 3);
        s_wb_rd[k*AW +: AW] = AW'($urandom_range(0, 7));
        s_wb_wdata[k*XLEN +: XLEN] = $urandom();
      end
      step();
    end
    idle_stage(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter RF_DEPTH, default 32, number of architectural registers; AW = clog2(RF_DEPTH).
REQ-003 Parameter NUM_WR, default 2, number of independent write-back ports.
REQ-004 Port clk  in  1  sole clock, all state on rising edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port id_tvalid  in  1  issue request valid.
REQ-007 Port id_tready  out  1  issue request accepted when high with id_tvalid.
REQ-008 Port id_rs1 / id_rs2  in  AW each  source register indices.
REQ-009 Port id_rs1_en / id_rs2_en  in  1 each  source actually read.
REQ-010 Port id_rd  in  AW  destination index; id_rd_en  in  1  destination written later.
REQ-011 Port ex_tvalid  out  1; ex_tready  in  1  output handshake to execution units.
REQ-012 Port ex_rs1_data / ex_rs2_data  out  XLEN each; ex_rd  out  AW; ex_rd_en  out  1.
REQ-013 Port wb_tvalid  in  NUM_WR; wb_rd  in  NUM_WR*AW; wb_wdata  in  NUM_WR*XLEN; wb_tready  out  NUM_WR, tied all-ones.
REQ-014 Port invalidate  in  1  pipeline flush.

Function
REQ-015 Register 0 SHALL read as zero, ignore writes, never be marked busy.
REQ-016 Write port k is effective when wb_tvalid[k] and wb_rd[k] != 0; effective writes update the array on the next edge.
REQ-017 Two effective writes to the same index in one cycle: highest port index wins, for both array and forwarding.
REQ-018 Source read data = wdata of highest-index effective write port matching the index this cycle, else array content; x0 always 0; disabled source reads 0.
REQ-019 A busy bit per register SHALL be set on an accepted issue with id_rd_en and id_rd != 0, and cleared by any effective write to that index.
REQ-020 Same-cycle set and clear of one busy bit: set wins.
REQ-021 Source hazard: enabled source busy and not cleared by an effective write this cycle.
REQ-022 Destination hazard (WAW): id_rd_en, id_rd != 0, busy, not cleared this cycle.
REQ-023 id_tready = !hazard && !invalidate && (!ex_tvalid || ex_tready); combinational, independent of id_tvalid.
REQ-024 Accepted issue SHALL appear on ex_* the next cycle (latency 1), registered.
REQ-025 ex_* SHALL hold stable while ex_tvalid && !ex_tready.
REQ-026 ex_tvalid cleared after a transfer unless a new issue is accepted the same cycle (full throughput, 1/cycle).
REQ-027 invalidate: next edge clears ex_tvalid and all busy bits; issue not accepted that cycle; array writes still occur.
REQ-028 Write-back ports never stall.

Reset
REQ-029 During rst: ex_tvalid=0, ex_rs1_data=ex_rs2_data=0, ex_rd=0, ex_rd_en=0, all busy bits 0, all registers 0.
REQ-030 Reset asserted mid-operation SHALL discard pending output and scoreboard immediately (asynchronously); id_tready SHALL be 0 while rst high.

Verification
REQ-031 Write x5=0x1234 via port 0, then issue rs1=5 -> ex_rs1_data=0x1234 one cycle later.
REQ-032 Issue rd=7 en; next issue rs1=7 -> id_tready=0 until wb port 1 writes x7=0xAA; that cycle id_tready=1, ex_rs1_data=0xAA.
REQ-033 Ports 0,1 both write x3 (0x11, 0x22) same cycle -> x3 reads 0x22; write x0=0xFF -> x0 reads 0.
REQ-034 ex_tready low 3 cycles with ex_tvalid=1 -> ex_* stable, id_tready=0; then back-to-back issues at one per cycle.
REQ-035 Issue rd=9, assert invalidate -> ex_tvalid=0 next cycle, issue rs1=9 accepted without stall.
REQ-036 Assert rst asynchronously with ex_tvalid=1 and busy bits set -> ex_tvalid=0, busy cleared before next edge.
